// File: rtl/fp_norm_pipe.sv
// Two-stage normalisation pipeline between the mantissa adder and the round/pack stage.
// Stage A captures the operands and leading-zero count; stage B shifts, adjusts the exponent and raises flags.
module fp_norm_pipe #(
  parameter int MANT_W    = 24,
  parameter int EXP_W     = 8,
  parameter int DENORM_EN = 1,
  parameter int CNT_W     = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   sum_mant,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] norm_mant,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_out,
  output logic [CNT_W-1:0]  lz_count,
  output logic              guard_out,
  output logic              zero_flag,
  output logic              ovf_flag,
  output logic              unf_flag
);

  // Stage A state
  logic              va;
  logic [MANT_W:0]   a_sum;
  logic [EXP_W-1:0]  a_exp;
  logic              a_sign;
  logic              a_carry;
  logic [CNT_W-1:0]  a_lz;

  logic              vb;
  logic              adv_b;
  logic [CNT_W-1:0]  lz_raw;

  assign adv_b     = !vb || out_ready;
  assign in_ready  = !va || adv_b;
  assign out_valid = vb;

  // Priority encoder: the highest set bit wins because it is visited last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    lz_raw = CNT_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (sum_mant[i]) lz_raw = CNT_W'(MANT_W - 1 - i);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    if (rst) va <= 1'b0;
    else if (in_ready) va <= in_valid;
  end

  // NOTE: payload registers are not reset; the valid bit alone says whether they hold a live beat.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      a_sum   <= sum_mant;
      a_exp   <= exp_in;
      a_sign  <= sign_in;
      a_carry <= sum_mant[MANT_W];
      a_lz    <= lz_raw;
    end
  end

  // Stage B combinational datapath
  logic [MANT_W-1:0]      a_low;
  logic [EXP_W:0]         exp_inc;
  logic signed [EXP_W:0]  exp_diff;
  logic [EXP_W-1:0]       denorm_shift;

  logic [MANT_W-1:0] n_mant;
  logic [EXP_W-1:0]  n_exp;
  logic              n_sign;
  logic [CNT_W-1:0]  n_lz;
  logic              n_guard;
  logic              n_zero;
  logic              n_ovf;
  logic              n_unf;

  assign a_low        = a_sum[MANT_W-1:0];
  assign exp_inc      = {1'b0, a_exp} + (EXP_W+1)'(1);
  // One extra bit, signed, so subtracting the shift count cannot wrap.
  assign exp_diff     = $signed({1'b0, a_exp}) - $signed((EXP_W+1)'(a_lz));
  assign denorm_shift = (a_exp == '0) ? '0 : a_exp - EXP_W'(1);

  always_comb begin
    n_mant  = '0;
    n_exp   = '0;
    n_sign  = a_sign;
    n_lz    = a_lz;
    n_guard = 1'b0;
    n_zero  = 1'b0;
    n_ovf   = 1'b0;
    n_unf   = 1'b0;
    if (a_carry) begin
      n_lz    = '0;
      n_guard = a_sum[0];
      if (exp_inc >= {1'b0, {EXP_W{1'b1}}}) begin
        n_ovf = 1'b1;
        n_exp = '1;
      end else begin
        n_mant = a_sum[MANT_W:1];
        n_exp  = exp_inc[EXP_W-1:0];
      end
    end else if (a_low == '0) begin
      n_zero = 1'b1;
      n_sign = 1'b0;
      n_lz   = CNT_W'(MANT_W);
    end else if (exp_diff >= (EXP_W+1)'(1)) begin
      n_mant = a_low << a_lz;
      n_exp  = exp_diff[EXP_W-1:0];
    end else begin
      // Underflow: either denormalise against the minimum exponent or flush.
      n_unf = 1'b1;
      if (DENORM_EN != 0) n_mant = a_low << denorm_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vb        <= 1'b0;
      norm_mant <= '0;
      exp_out   <= '0;
      sign_out  <= 1'b0;
      lz_count  <= '0;
      guard_out <= 1'b0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      unf_flag  <= 1'b0;
    end else if (adv_b) begin
      vb <= va;
      if (va) begin
        norm_mant <= n_mant;
        exp_out   <= n_exp;
        sign_out  <= n_sign;
        lz_count  <= n_lz;
        guard_out <= n_guard;
        zero_flag <= n_zero;
        ovf_flag  <= n_ovf;
        unf_flag  <= n_unf;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe: directed vector table, backpressure/reset sequences
// and randomized traffic against an arithmetic reference model, run on denormal and flush-to-zero builds.
module tb_fp_norm_pipe;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, out_ready, sign_in;
  logic [MW:0]   sum_mant;
  logic [EW-1:0] exp_in;

  logic          in_ready_d, out_valid_d, sign_d, guard_d, zero_d, ovf_d, unf_d;
  logic [MW-1:0] mant_d;
  logic [EW-1:0] exp_d;
  logic [CW-1:0] lz_d;
  logic          in_ready_f, out_valid_f, sign_f, guard_f, zero_f, ovf_f, unf_f;
  logic [MW-1:0] mant_f;
  logic [EW-1:0] exp_f;
  logic [CW-1:0] lz_f;

  fp_norm_pipe #(.MANT_W(MW), .EXP_W(EW), .DENORM_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
    .sum_mant(sum_mant), .exp_in(exp_in), .sign_in(sign_in),
    .out_valid(out_valid_d), .out_ready(out_ready),
    .norm_mant(mant_d), .exp_out(exp_d), .sign_out(sign_d), .lz_count(lz_d),
    .guard_out(guard_d), .zero_flag(zero_d), .ovf_flag(ovf_d), .unf_flag(unf_d));

  fp_norm_pipe #(.MANT_W(MW), .EXP_W(EW), .DENORM_EN(0)) dut_ftz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
    .sum_mant(sum_mant), .exp_in(exp_in), .sign_in(sign_in),
    .out_valid(out_valid_f), .out_ready(out_ready),
    .norm_mant(mant_f), .exp_out(exp_f), .sign_out(sign_f), .lz_count(lz_f),
    .guard_out(guard_f), .zero_flag(zero_f), .ovf_flag(ovf_f), .unf_flag(unf_f));

  // Result word: {mant, exp, sign, lz, guard, zero, ovf, unf}
  logic [41:0] got_d, got_f;
  assign got_d = {mant_d, exp_d, sign_d, lz_d, guard_d, zero_d, ovf_d, unf_d};
  assign got_f = {mant_f, exp_f, sign_f, lz_f, guard_f, zero_f, ovf_f, unf_f};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [41:0] pack(longint m, int e, bit s, int lz, bit g, bit z, bit o, bit u);
    return {24'(m), 8'(e), s, 5'(lz), g, z, o, u};
  endfunction

  // Reference: normalise by doubling until the hidden bit is set.
  function automatic logic [41:0] model(logic [MW:0] s, logic [EW-1:0] e, logic sg, bit den);
    longint m;
    int lz;
    int ei;
    ei = int'(e);
    if (s[MW]) begin
      if (ei + 1 >= 255) return pack(0, 255, sg, 0, s[0], 0, 1, 0);
      return pack(longint'(s) / 2, ei + 1, sg, 0, s[0], 0, 0, 0);
    end
    m = longint'(s[MW-1:0]);
    if (m == 0) return pack(0, 0, 0, MW, 0, 1, 0, 0);
    lz = 0;
    while (m < (longint'(1) << (MW - 1))) begin
      m = m * 2;
      lz++;
    end
    if (ei - lz >= 1) return pack(m, ei - lz, sg, lz, 0, 0, 0, 0);
    if (den) return pack(longint'(s[MW-1:0]) << ((ei > 0) ? ei - 1 : 0), 0, sg, lz, 0, 0, 0, 1);
    return pack(0, 0, sg, lz, 0, 0, 0, 1);
  endfunction

  typedef struct {
    logic [41:0] xd;
    logic [41:0] xf;
  } exp_t;
  exp_t sb[$];

  bit          stall_prev = 1'b0;
  logic [41:0] snap_d, snap_f;

  // One clock: settle, check handshake/outputs against the scoreboard, then advance.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    check("in_ready", in_ready_d, !(sb.size() == 2 && !out_ready));
    check("in_ready_ftz", in_ready_f, !(sb.size() == 2 && !out_ready));
    if (stall_prev) begin
      check("hold_valid", out_valid_d, 1);
      check("hold_data", got_d, snap_d);
      check("hold_data_ftz", got_f, snap_f);
    end
    if (out_valid_d && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_beat: got out_valid=1 expected no beat in flight");
      end else begin
        e = sb.pop_front();
        check("beat", got_d, e.xd);
        check("beat_ftz_valid", out_valid_f, 1);
        check("beat_ftz", got_f, e.xf);
      end
    end
    stall_prev = out_valid_d && !out_ready;
    snap_d = got_d;
    snap_f = got_f;
    acc = in_valid && in_ready_d;
    if (acc) begin
      e.xd = model(sum_mant, exp_in, sign_in, 1'b1);
      e.xf = model(sum_mant, exp_in, sign_in, 1'b0);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [MW:0] s, input logic [EW-1:0] e, input logic sg);
    sum_mant = s;
    exp_in   = e;
    sign_in  = sg;
  endtask

  task automatic rand_beat();
    logic [MW:0] s;
    int kind;
    kind = $urandom_range(0, 9);
    s = (MW+1)'($urandom);
    case (kind)
      0:       s[MW] = 1'b1;
      1:       s = '0;
      2, 3:    begin s[MW] = 1'b0; s = s >> $urandom_range(0, MW - 1); end
      default: s[MW] = 1'b0;
    endcase
    drive(s, ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 255)) : EW'($urandom_range(0, 30)),
          1'($urandom));
  endtask

  typedef struct {
    logic [MW:0]   sum;
    logic [EW-1:0] e;
    logic          sg;
    logic [41:0]   xd;
    logic [41:0]   xf;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;

    vecs[0] = '{25'h1000001, 8'd127, 1'b0, pack(24'h800000, 128, 0, 0, 1, 0, 0, 0), pack(24'h800000, 128, 0, 0, 1, 0, 0, 0)};
    vecs[1] = '{25'h0001234, 8'd100, 1'b0, pack(24'h91A000, 89, 0, 11, 0, 0, 0, 0), pack(24'h91A000, 89, 0, 11, 0, 0, 0, 0)};
    vecs[2] = '{25'h0000000, 8'd50,  1'b1, pack(0, 0, 0, 24, 0, 1, 0, 0), pack(0, 0, 0, 24, 0, 1, 0, 0)};
    vecs[3] = '{25'h0000100, 8'd10,  1'b1, pack(24'h020000, 0, 1, 15, 0, 0, 0, 1), pack(0, 0, 1, 15, 0, 0, 0, 1)};
    vecs[4] = '{25'h1800000, 8'd254, 1'b1, pack(0, 255, 1, 0, 0, 0, 1, 0), pack(0, 255, 1, 0, 0, 0, 1, 0)};
    vecs[5] = '{25'h0001234, 8'd12,  1'b0, pack(24'h91A000, 1, 0, 11, 0, 0, 0, 0), pack(24'h91A000, 1, 0, 11, 0, 0, 0, 0)};
    vecs[6] = '{25'h0001234, 8'd11,  1'b0, pack(24'h48D000, 0, 0, 11, 0, 0, 0, 1), pack(0, 0, 0, 11, 0, 0, 0, 1)};
    vecs[7] = '{25'h1FFFFFF, 8'd253, 1'b0, pack(24'hFFFFFF, 254, 0, 0, 1, 0, 0, 0), pack(24'hFFFFFF, 254, 0, 0, 1, 0, 0, 0)};
    vecs[8] = '{25'h0000100, 8'd0,   1'b0, pack(24'h000100, 0, 0, 15, 0, 0, 0, 1), pack(0, 0, 0, 15, 0, 0, 0, 1)};

    // Reset state
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", out_valid_d, 0);
    check("reset_outputs", got_d, 0);
    check("reset_outputs_ftz", got_f, 0);
    check("reset_in_ready", in_ready_d, 1);

    // Directed table: one isolated beat each, checking latency and result
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      drive(vecs[i].sum, vecs[i].e, vecs[i].sg);
      cycle(acc);
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1", i), out_valid_d, 0);
      cycle(acc);
      check($sformatf("vec%0d_valid", i), out_valid_d, 1);
      check($sformatf("vec%0d", i), got_d, vecs[i].xd);
      check($sformatf("vec%0d_ftz", i), got_f, vecs[i].xf);
      cycle(acc);
    end

    // Backpressure: 4 beats, out_ready low for 3 cycles
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      drive(25'h0000F00 + (MW+1)'(idx), EW'(60 + idx), idx[0]);
      cycle(acc);
      if (acc) idx++;
    end
    check("bp_accepted_while_stalled", idx, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || sb.size() > 0); c++) begin
      in_valid = (idx < 4);
      drive(25'h0000F00 + (MW+1)'(idx), EW'(60 + idx), idx[0]);
      cycle(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", idx, 4);
    check("bp_all_received", sb.size(), 0);

    // Reset during a stall discards in-flight beats
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      rand_beat();
      cycle(acc);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    check("rst_stall_out_valid", out_valid_d, 0);
    check("rst_stall_in_ready", in_ready_d, 1);
    check("rst_stall_outputs", got_d, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall_no_ghost", out_valid_d, 0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
      cycle(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) cycle(acc);
    check("random_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
# fp_norm_pipe

Parametrised two-stage normalisation pipeline for the floating-point adder datapath. It sits between the mantissa add/subtract stage and the rounding/pack stage. Each stage takes a raw sum mantissa that may include a carry-out, and a biased exponent. It produces a normalised mantissa, an adjusted exponent, exception flags and the shift count. Every stage uses a valid/ready handshake with full backpressure.

## Interface
- MANT_W, 24, mantissa width including hidden bit
- EXP_W, 8, biased exponent width
- DENORM_EN, 1, 1 = gradual underflow (subnormal output); 0 = flush-to-zero
- CNT_W, $clog2(MANT_W+1), width of lz_count
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input this cycle
- sum_mant  in  MANT_W+1  raw sum; bit MANT_W is the adder carry-out
- exp_in  in  EXP_W  biased exponent of larger operand
- sign_in  in  1  result sign
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- norm_mant  out  MANT_W  normalised mantissa, hidden bit at MSB when normal
- exp_out  out  EXP_W  adjusted biased exponent
- sign_out  out  1  result sign
- lz_count  out  CNT_W  leading zeros of sum_mant[MANT_W-1:0]; 0 on carry; MANT_W on zero
- guard_out  out  1  bit dropped by carry right-shift, else 0
- zero_flag, ovf_flag, unf_flag  out  1 each  exact zero / exponent overflow / underflow

## Operation
- Stage A registers: the carry bit, the priority-encoded leading-zero count of sum_mant[MANT_W-1:0], the raw operands and a valid bit va.
- Stage B registers: shift, exponent adjust and flag logic, plus vb. All outputs come from stage B registers.
- Carry (sum_mant[MANT_W]=1): shift right 1, guard_out = sum_mant[0], exp = exp_in+1.
  - If exp_in+1 ≥ 2^EXP_W−1: set ovf_flag, exp_out all-ones, norm_mant 0 (infinity), sign kept.
- All-zero sum: norm_mant 0, exp_out 0, sign_out 0, zero_flag 1, lz_count MANT_W.
- Otherwise, let lz = leading zeros.
  - If exp_in − lz ≥ 1: shift left by lz, exp_out = exp_in − lz.
  - Else underflow, unf_flag 1, exp_out 0:
    - DENORM_EN=1: shift left by max(exp_in−1, 0).
    - DENORM_EN=0: norm_mant 0, sign kept.
- Exponent arithmetic is done at EXP_W+1 bits signed so the lz subtraction cannot wrap.
- Flags are mutually exclusive; at most one is set per beat.

## Timing
- Reset: va, vb, out_valid 0. norm_mant, exp_out, sign_out, lz_count, guard_out and all flags 0. Reset wins over any simultaneous handshake. Reset mid-stream discards in-flight beats.
- Latency: 2 cycles from accepted input (in_valid & in_ready) to out_valid, with no stall. Throughput is 1 beat/cycle.
- adv_b = !vb | out_ready. in_ready = !va | adv_b, combinational, with no combinational path from in_valid.
- With out_valid=1 and out_ready=0, all outputs hold stable and no beat is dropped or duplicated.
- The pipeline holds at most 2 beats. in_ready falls only when va & vb & !out_ready.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.

## Test plan
- Carry: sum_mant=25'h1000001, exp_in=127 -> after 2 cycles norm_mant=24'h800000, exp_out=128, guard_out=1, lz_count=0.
- Left normalise: sum_mant=25'h0001234, exp_in=100 -> norm_mant=24'h91A000, exp_out=89, lz_count=11, no flags.
- Zero: sum_mant=0, exp_in=50, sign_in=1 -> norm_mant=0, exp_out=0, sign_out=0, zero_flag=1, lz_count=24.
- Underflow: sum_mant=25'h0000100, exp_in=10.
  - DENORM_EN=1 -> norm_mant=24'h020000, exp_out=0, unf_flag=1.
  - DENORM_EN=0 -> norm_mant=0, unf_flag=1.
- Overflow: sum_mant=25'h1800000, exp_in=254 -> exp_out=255, norm_mant=0, ovf_flag=1.
- Backpressure:
  - Stream 4 beats with out_ready=0 for 3 cycles -> in_ready drops after 2 beats held, outputs stable. Releasing out_ready delivers all 4 beats in order, no loss or duplicate.
  - Assert rst during a stall -> next cycle out_valid=0 and in_ready=1.
